// File: rtl/dm_responder.sv
// Single-port data-memory responder: accepts one load/store at a time, answers after
// LATENCY edges with ack, sub-word lanes in little-endian order, misaligned accesses flagged.
module dm_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        load_u_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [1:0]     size_q;
    logic           load_u_q;
    logic [31:0]    rdata_q;
    logic [31:0]    mem_q [DEPTH];

    logic           acc_we;
    logic [AW+1:0]  acc_addr;
    logic [31:0]    acc_wdata;
    logic [1:0]     acc_size;
    logic           acc_load_u;
    logic           enter_resp;
    logic           unused_addr;

    assign unused_addr = ^addr_i[31:AW+2];

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = 1'b0;
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_w, input logic [31:0] d,
                                                input logic [1:0] size, input logic [1:0] off);
        store_merge = old_w;
        case (size)
            2'b10:   store_merge[{off, 3'b000} +: 8] = d[7:0];
            2'b01:   store_merge[{off[1], 4'b0000} +: 16] = d[15:0];
            default: store_merge = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                                 input logic [1:0] off, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (size)
            2'b10:   load_extract = u ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_extract = u ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extract = w;
        endcase
    endfunction

    // With LATENCY=1 the commit happens on the accept edge, so use the live inputs in IDLE.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we     = we_i;
            acc_addr   = addr_i[AW+1:0];
            acc_wdata  = wdata_i;
            acc_size   = size_i;
            acc_load_u = load_u_i;
        end else begin
            acc_we     = we_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
            acc_size   = size_q;
            acc_load_u = load_u_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (LATENCY == 1) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp && !misaligned(acc_size, acc_addr[1:0])) begin
                if (acc_we)
                    mem_q[acc_addr[AW+1:2]] <= store_merge(mem_q[acc_addr[AW+1:2]], acc_wdata,
                                                           acc_size, acc_addr[1:0]);
                else
                    rdata_q <= load_extract(mem_q[acc_addr[AW+1:2]], acc_size,
                                            acc_addr[1:0], acc_load_u);
            end
        end
    end

    // Access attributes are frozen at acceptance; later input activity is ignored.
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE && req_i) begin
            we_q     <= we_i;
            addr_q   <= addr_i[AW+1:0];
            wdata_q  <= wdata_i;
            size_q   <= size_i;
            load_u_q <= load_u_i;
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign ack_o   = (state_q == S_RESP);
    assign err_o   = (state_q == S_RESP) && misaligned(size_q, addr_q[1:0]);
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder (LATENCY=2, DEPTH=1024): timing, lanes, extension,
// misalignment, wrap, request filtering while busy, and reset behaviour.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset, req, we, load_u;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        busy, ack, err;
    logic [31:0] rdata;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dm_responder #(.LATENCY(2), .DEPTH(1024)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .size_i(size), .load_u_i(load_u),
        .busy_o(busy), .ack_o(ack), .rdata_o(rdata), .err_o(err)
    );

    // One access: n = edges from acceptance (counted as 1) to the first ack cycle.
    // Inputs are scrambled right after acceptance; they must not disturb the access.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic u, output int n,
                          output logic [31:0] rd, output logic e, output logic clean);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; size = s; load_u = u;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; addr = ~a; wdata = ~d; size = ~s; load_u = ~u;
        n = 1;
        while (!ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        rd = rdata;
        e  = err;
        @(posedge clk); #1;
        clean = !ack && !busy;
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
        compared++; if (ack !== 1'b0) begin mismatched++; $display("FAIL rst_ack: got %b want 0", ack); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", err); end
        compared++; if (rdata !== 32'h0) begin mismatched++; $display("FAIL rst_rdata: got %h want 00000000", rdata); end
        // req has been high throughout reset; it must be taken only at the first edge after release
        @(negedge clk);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_req_ignored: busy %b want 0", busy); end
        reset = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rst_first_accept: busy %b want 1", busy); end
        n = 1;
        while (!ack && n < 20) begin @(posedge clk); #1; n++; end
        compared++; if (n !== 2) begin mismatched++; $display("FAIL rst_first_lat: got %0d edges want 2", n); end
        compared++; if (rdata !== 32'h0) begin mismatched++; $display("FAIL rst_first_rdata: got %h want 00000000", rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        int n; logic [31:0] rd; logic e, cl;
        access(1'b1, 32'h10, 32'h12345678, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (n !== 2) begin mismatched++; $display("FAIL sw_lat: got %0d edges want 2", n); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL sw_err: got %b want 0", e); end
        compared++; if (cl !== 1'b1) begin mismatched++; $display("FAIL sw_idle_after: ack/busy not low (%b) want 1", cl); end
        access(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (n !== 2) begin mismatched++; $display("FAIL lw_lat: got %0d edges want 2", n); end
        compared++; if (rd !== 32'h12345678) begin mismatched++; $display("FAIL lw_rdata: got %h want 12345678", rd); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL lw_err: got %b want 0", e); end
        compared++; if (cl !== 1'b1) begin mismatched++; $display("FAIL lw_idle_after: got %b want 1", cl); end
        compared++; if (rdata !== 32'h12345678) begin mismatched++; $display("FAIL lw_hold: got %h want 12345678", rdata); end
    endtask

    task automatic test_byte();
        int n; logic [31:0] rd; logic e, cl;
        access(1'b1, 32'h13, 32'hFFFF_FFAB, 2'b10, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'h12345678) begin mismatched++; $display("FAIL sb_rdata_hold: got %h want 12345678", rd); end
        access(1'b0, 32'h13, 32'h0, 2'b10, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'hFFFFFFAB) begin mismatched++; $display("FAIL lb_signed: got %h want ffffffab", rd); end
        access(1'b0, 32'h13, 32'h0, 2'b10, 1'b1, n, rd, e, cl);
        compared++; if (rd !== 32'h000000AB) begin mismatched++; $display("FAIL lbu: got %h want 000000ab", rd); end
        access(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'hAB345678) begin mismatched++; $display("FAIL lw_after_sb: got %h want ab345678", rd); end
        access(1'b0, 32'h11, 32'h0, 2'b10, 1'b1, n, rd, e, cl);
        compared++; if (rd !== 32'h00000056) begin mismatched++; $display("FAIL lbu_lane1: got %h want 00000056", rd); end
    endtask

    task automatic test_half();
        int n; logic [31:0] rd; logic e, cl;
        access(1'b1, 32'h22, 32'h0000_8001, 2'b01, 1'b0, n, rd, e, cl);
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL sh_err: got %b want 0", e); end
        access(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'hFFFF8001) begin mismatched++; $display("FAIL lh_signed: got %h want ffff8001", rd); end
        access(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, n, rd, e, cl);
        compared++; if (rd !== 32'h00008001) begin mismatched++; $display("FAIL lhu: got %h want 00008001", rd); end
        access(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'h80010000) begin mismatched++; $display("FAIL lw_after_sh: got %h want 80010000", rd); end
        access(1'b0, 32'h20, 32'h0, 2'b11, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'h80010000) begin mismatched++; $display("FAIL lw_reserved: got %h want 80010000", rd); end
    endtask

    task automatic test_misaligned();
        int n; logic [31:0] rd; logic e, cl;
        access(1'b1, 32'h4, 32'h55AA1234, 2'b00, 1'b0, n, rd, e, cl);
        access(1'b0, 32'h4, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'h55AA1234) begin mismatched++; $display("FAIL mis_setup: got %h want 55aa1234", rd); end
        access(1'b0, 32'h2, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL mis_lw_err: got %b want 1", e); end
        compared++; if (rd !== 32'h55AA1234) begin mismatched++; $display("FAIL mis_lw_rdata: got %h want 55aa1234", rd); end
        compared++; if (n !== 2) begin mismatched++; $display("FAIL mis_lw_lat: got %0d edges want 2", n); end
        access(1'b1, 32'h5, 32'h0000_BEEF, 2'b01, 1'b0, n, rd, e, cl);
        compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL mis_sh_err: got %b want 1", e); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL mis_err_after: got %b want 0", err); end
        access(1'b0, 32'h4, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'h55AA1234) begin mismatched++; $display("FAIL mis_mem_kept: got %h want 55aa1234", rd); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL mis_aligned_err: got %b want 0", e); end
    endtask

    task automatic test_wait_ignore();
        int n; logic [31:0] rd; logic e, cl;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h11111111; size = 2'b00; load_u = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; addr = 32'h34; wdata = 32'h22222222;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL wait_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        req = 1'b0;
        compared++; if (ack !== 1'b1 || busy !== 1'b1) begin mismatched++; $display("FAIL wait_ack: ack %b busy %b want 1 1", ack, busy); end
        @(posedge clk); #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL wait_no_accept: busy %b want 0", busy); end
        access(1'b0, 32'h34, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL wait_ignored_store: got %h want 00000000", rd); end
        access(1'b0, 32'h30, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'h11111111) begin mismatched++; $display("FAIL wait_orig_store: got %h want 11111111", rd); end
        access(1'b1, 32'h1000, 32'hCAFEF00D, 2'b00, 1'b0, n, rd, e, cl);
        access(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'hCAFEF00D) begin mismatched++; $display("FAIL wrap_word0: got %h want cafef00d", rd); end
        access(1'b0, 32'h8000_0000, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'hCAFEF00D) begin mismatched++; $display("FAIL wrap_high_bits: got %h want cafef00d", rd); end
    endtask

    task automatic test_reset_abort();
        int n; logic [31:0] rd; logic e, cl; int acks;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hDEADBEEF; size = 2'b00; load_u = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        reset = 1'b1;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL abort_in_wait: busy %b want 1", busy); end
        @(posedge clk); #1;
        compared++; if (busy !== 1'b0 || ack !== 1'b0) begin mismatched++; $display("FAIL abort_state: busy %b ack %b want 0 0", busy, ack); end
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        repeat (5) begin @(posedge clk); #1; if (ack) acks++; end
        compared++; if (acks !== 0) begin mismatched++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
        access(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, n, rd, e, cl);
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL abort_no_commit: got %h want 00000000", rd); end
        compared++; if (n !== 2) begin mismatched++; $display("FAIL abort_next_lat: got %0d edges want 2", n); end
    endtask

    initial begin
        reset = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; size = 2'b00; load_u = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_wait_ignore();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
